// File: rtl/phy_rst_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phy_rst_seq_pkg
//  Description : Shared state encodings and sizing helper for the reset
//                sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package phy_rst_seq_pkg;

    typedef enum logic [1:0] {
        G_COLD    = 2'd0,
        G_STAGGER = 2'd1,
        G_RUN     = 2'd2
    } glb_state_t;

    typedef enum logic [1:0] {
        CH_RESET  = 2'd0,
        CH_SETTLE = 2'd1,
        CH_READY  = 2'd2,
        CH_SOFT   = 2'd3
    } chan_state_t;

    localparam int SYNC_STAGES = 2;

    // Width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/phy_rst_chan.sv
`default_nettype none
// ============================================================================
//  Module      : phy_rst_chan
//  Description : One PHY reset channel: release, settle, ready and soft reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_rst_chan
    import phy_rst_seq_pkg::*;
#(
    parameter int READY_DELAY = 64,
    parameter int SOFT_CYCLES = 520
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ext_low,
    input  logic i_release,
    input  logic i_soft_req,
    output logic o_phy_rst_n,
    output logic o_phy_ready,
    output logic o_busy
);

    localparam int CNT_MAX = (READY_DELAY > SOFT_CYCLES) ? READY_DELAY : SOFT_CYCLES;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(CNT_MAX);

    chan_state_t      r_state;
    chan_state_t      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_phy_rst_n;
    logic             r_phy_ready;
    logic             w_settle_done;
    logic             w_soft_done;

    assign w_settle_done = (32'(r_cnt) + 32'd1) >= 32'(READY_DELAY);
    assign w_soft_done   = (32'(r_cnt) + 32'd1) >= 32'(SOFT_CYCLES);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CH_RESET:  if (i_release)          w_state_next = CH_SETTLE;
            CH_SETTLE: if (i_soft_req)         w_state_next = CH_SOFT;
                       else if (w_settle_done) w_state_next = CH_READY;
            CH_READY:  if (i_soft_req)         w_state_next = CH_SOFT;
            CH_SOFT:   if (w_soft_done)        w_state_next = CH_SETTLE;
            default:                           w_state_next = CH_RESET;
        endcase
        // Push-button reset overrides everything, including soft requests.
        if (i_ext_low) begin
            w_state_next = CH_RESET;
        end
    end

    always_comb begin
        w_cnt_next = '0;
        if ((w_state_next == r_state) &&
            ((r_state == CH_SETTLE) || (r_state == CH_SOFT))) begin
            w_cnt_next = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= CH_RESET;
            r_cnt       <= '0;
            r_phy_rst_n <= 1'b0;
            r_phy_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_phy_rst_n <= (w_state_next == CH_SETTLE) || (w_state_next == CH_READY);
            r_phy_ready <= (w_state_next == CH_READY);
        end
    end

    assign o_phy_rst_n = r_phy_rst_n;
    assign o_phy_ready = r_phy_ready;
    assign o_busy      = (r_state != CH_READY);

endmodule
`default_nettype wire

// File: rtl/phy_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : phy_rst_seq
//  Description : Core reset release plus staggered, soft-resettable PHY resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_rst_seq
    import phy_rst_seq_pkg::*;
#(
    parameter int NUM_PHY        = 2,
    parameter int CORE_CYCLES    = 1048576,
    parameter int COLD_CYCLES    = 520,
    parameter int STAGGER_CYCLES = 16,
    parameter int SOFT_CYCLES    = 520,
    parameter int READY_DELAY    = 64
) (
    input  logic               clk_125,
    input  logic               sys_rst,
    input  logic               ext_reset_n,
    input  logic [NUM_PHY-1:0] soft_rst_req,
    output logic               core_rst_n,
    output logic [NUM_PHY-1:0] phy_rst_n,
    output logic [NUM_PHY-1:0] phy_ready,
    output logic               busy
);

    localparam int CORE_W   = cnt_width(CORE_CYCLES);
    localparam int COLD_W   = cnt_width(COLD_CYCLES);
    localparam int LAST_POS = (NUM_PHY - 1) * STAGGER_CYCLES;
    localparam int STG_W    = cnt_width(LAST_POS);
    localparam logic [CORE_W-1:0] C_CORE_MAX = CORE_W'(CORE_CYCLES);

    logic [SYNC_STAGES-1:0] r_ext_sync;
    logic                   w_ext_low;
    logic [CORE_W-1:0]      r_core_cnt;
    logic                   r_core_rst_n;
    glb_state_t             r_gstate;
    glb_state_t             w_gstate_next;
    logic [COLD_W-1:0]      r_cold_cnt;
    logic [STG_W-1:0]       r_stg_cnt;
    logic                   w_cold_done;
    logic                   w_rel_tick;
    logic [31:0]            w_rel_pos;
    logic [NUM_PHY-1:0]     w_release;
    logic [NUM_PHY-1:0]     w_chan_busy;

    // Synchroniser idles deasserted so a clean sys_rst release is not delayed.
    always_ff @(posedge clk_125 or posedge sys_rst) begin
        if (sys_rst) begin
            r_ext_sync <= '1;
        end else begin
            r_ext_sync <= {r_ext_sync[SYNC_STAGES-2:0], ext_reset_n};
        end
    end

    assign w_ext_low = ~r_ext_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_125 or posedge sys_rst) begin
        if (sys_rst) begin
            r_core_cnt   <= '0;
            r_core_rst_n <= 1'b0;
        end else begin
            if (r_core_cnt != C_CORE_MAX) begin
                r_core_cnt <= r_core_cnt + 1'b1;
            end
            r_core_rst_n <= (32'(r_core_cnt) + 32'd1) >= 32'(CORE_CYCLES);
        end
    end

    // Release slot k is offered in the cycle before edge COLD_CYCLES + k.
    assign w_cold_done = (r_gstate == G_COLD) &&
                         ((32'(r_cold_cnt) + 32'd1) >= 32'(COLD_CYCLES));
    assign w_rel_tick  = ~w_ext_low && (w_cold_done || (r_gstate == G_STAGGER));
    assign w_rel_pos   = (r_gstate == G_STAGGER) ? (32'(r_stg_cnt) + 32'd1) : 32'd0;

    always_comb begin
        w_gstate_next = r_gstate;
        case (r_gstate)
            G_COLD:    if (w_cold_done) w_gstate_next = (LAST_POS == 0) ? G_RUN : G_STAGGER;
            G_STAGGER: if (w_rel_pos >= 32'(LAST_POS)) w_gstate_next = G_RUN;
            G_RUN:     w_gstate_next = G_RUN;
            default:   w_gstate_next = G_COLD;
        endcase
        if (w_ext_low) begin
            w_gstate_next = G_COLD;
        end
    end

    always_ff @(posedge clk_125 or posedge sys_rst) begin
        if (sys_rst) begin
            r_gstate <= G_COLD;
        end else begin
            r_gstate <= w_gstate_next;
        end
    end

    always_ff @(posedge clk_125 or posedge sys_rst) begin
        if (sys_rst) begin
            r_cold_cnt <= '0;
            r_stg_cnt  <= '0;
        end else if (w_ext_low) begin
            r_cold_cnt <= '0;
            r_stg_cnt  <= '0;
        end else begin
            if ((r_gstate == G_COLD) && !w_cold_done) begin
                r_cold_cnt <= r_cold_cnt + 1'b1;
            end
            if ((r_gstate == G_STAGGER) && (w_gstate_next == G_STAGGER)) begin
                r_stg_cnt <= r_stg_cnt + 1'b1;
            end else begin
                r_stg_cnt <= '0;
            end
        end
    end

    for (genvar g = 0; g < NUM_PHY; g++) begin : g_chan
        localparam int REL_POS = g * STAGGER_CYCLES;

        assign w_release[g] = w_rel_tick && (w_rel_pos == 32'(REL_POS));

        phy_rst_chan #(
            .READY_DELAY (READY_DELAY),
            .SOFT_CYCLES (SOFT_CYCLES)
        ) u_chan (
            .clk         (clk_125),
            .rst         (sys_rst),
            .i_ext_low   (w_ext_low),
            .i_release   (w_release[g]),
            .i_soft_req  (soft_rst_req[g]),
            .o_phy_rst_n (phy_rst_n[g]),
            .o_phy_ready (phy_ready[g]),
            .o_busy      (w_chan_busy[g])
        );
    end

    assign core_rst_n = r_core_rst_n;
    assign busy       = |w_chan_busy;

endmodule
`default_nettype wire
